dmem_access_ctrl: RTL and testbench
===================================

// Module: dmem_access_ctrl
// PURPOSE
//  MEM-stage initiator toward a variable-latency data memory. Takes the EX/MEM register outputs
//  (WB_MEM, MEM_Opcode, MEM_ALU_RESULT, MEM_RT_DATA), issues a req/ack transaction and stalls the
//  pipeline until it completes. Handles byte/half/word lanes, load sign-extension, misalignment and timeout.
// PARAMETERS
//  TIMEOUT_CYCLES  255  cycles in REQ without Mem_Ack before abort (1..255)
//  ADDR_W          32   address width
// PORTS
//  CLK             in   1   clock; all state updates on the rising edge
//  RESET           in   1   synchronous, active-high reset
//  WB_MEM          in   5   EX/MEM control; bit0=MemWrite, bit1=MemRead
//  MEM_Opcode      in   6   lb 100000, lh 100001, lw 100011, lbu 100100, lhu 100101, sb 101000, sh 101001, sw 101011
//  MEM_ALU_RESULT  in   32  byte address
//  MEM_RT_DATA     in   32  store data (low bytes used for sb/sh)
//  Mem_Req         out  1   request valid; held until Mem_Ack
//  Mem_We          out  1   1 = write
//  Mem_Addr        out  32  word address {addr[31:2],2'b00}
//  Mem_WData       out  32  lane-replicated store data
//  Mem_BE          out  4   byte enables; bit n = bits[8n+7:8n]
//  Mem_Ack         in   1   one-cycle completion pulse from memory
//  Mem_RData       in   32  read word, valid with Mem_Ack
//  Read_data       out  32  formatted load result for MEM/WB
//  Stall           out  1   combinational; freezes PC/IF/ID/EX/MEM regs
//  Align_Err       out  1   one-cycle pulse: misaligned access dropped
//  Bus_Err         out  1   one-cycle pulse: timeout abort
// BEHAVIOUR
//  - Reset: state IDLE, Mem_Req=0, Mem_We=0, Mem_Addr=0, Mem_WData=0, Mem_BE=0, Read_data=0,
//    Align_Err=0, Bus_Err=0, timeout counter=0. Reset mid-transaction drops Mem_Req at that same edge; no wait for ack.
//  - access = WB_MEM[0]|WB_MEM[1]; MemWrite wins if both set. Unlisted opcode: lw if read, sw if write.
//  - Little-endian lanes: addr[1:0]=0 selects bits[7:0].
//  - Misaligned: half with addr[0]=1, word with addr[1:0]!=0.
//  - FSM IDLE/REQ/DONE:
//    IDLE: access & aligned -> Stall=1, register Mem_* outputs, go REQ (Mem_Req high next cycle).
//          access & misaligned -> Align_Err=1 next cycle, no request, no stall, stay IDLE.
//          no access -> Stall=0.
//    REQ:  Stall=1; Mem_* stable. Mem_Ack -> Mem_Req=0; on read, Read_data<=fmt(Mem_RData); go DONE.
//          Counter reaches TIMEOUT_CYCLES with no ack -> Mem_Req=0, Bus_Err=1, Read_data=0, go DONE.
//    DONE: Stall=0 (pipeline advances once, so the same instruction is not re-issued); go IDLE.
//  - Latency: memory ack after k cycles in REQ -> Stall high k+1 cycles, Read_data valid in DONE.
//  - Stores: sb BE=1<<addr[1:0], WData={4{rt[7:0]}}; sh BE=addr[1]?1100:0011, WData={2{rt[15:0]}};
//    sw BE=1111. Reads: Mem_BE=1111, Mem_WData=0.
//  - Loads: lb/lh sign-extend the selected lane; lbu/lhu zero-extend; lw passes the word.
//    Read_data holds its value until the next load completes; stores leave it unchanged.
//  - Mem_Ack in IDLE/DONE is ignored. Ack in the same cycle as timeout: the ack wins and Bus_Err=0.
// STRUCTURE
//  - Package mem_access_pkg: opcode localparams, WB_MEM bit indices, FSM state encodings, lane/BE constants.
//  - Sub-module dmem_lane_fmt (combinational): store lane/BE generation plus load extract/extend.
//    The FSM, counter and registers stay in the top level.
// TESTING
//  1. lw addr=4, ack after 3 cycles with 0xDEADBEEF -> Mem_Addr=4, BE=1111, Stall high 4 cycles, Read_data=0xDEADBEEF.
//  2. sb addr=0x0B rt=0x000000A5, immediate ack -> Mem_We=1, BE=1000, WData=0xA5A5A5A5, Stall high 2 cycles.
//  3. lb addr=0x0A, RData=0x00800000 -> Read_data=0xFFFFFF80; lbu same -> 0x00000080.
//  4. lh addr=0x05 -> Align_Err pulse, Mem_Req never high, Stall=0.
//  5. TIMEOUT_CYCLES=4, lw with no ack -> Bus_Err after 4 REQ cycles, Read_data=0, DONE then IDLE.
//  6. RESET asserted during REQ -> next edge Mem_Req=0, state IDLE; late Mem_Ack ignored.

Source files
------------

// File: rtl/mem_access_pkg.sv
// Shared constants for the MEM-stage data-memory initiator: opcodes, control bits,
// FSM states, byte-enable patterns and opcode decode helpers.
package mem_access_pkg;

   localparam logic [5:0] OP_LB  = 6'b100000;
   localparam logic [5:0] OP_LH  = 6'b100001;
   localparam logic [5:0] OP_LW  = 6'b100011;
   localparam logic [5:0] OP_LBU = 6'b100100;
   localparam logic [5:0] OP_LHU = 6'b100101;
   localparam logic [5:0] OP_SB  = 6'b101000;
   localparam logic [5:0] OP_SH  = 6'b101001;
   localparam logic [5:0] OP_SW  = 6'b101011;

   localparam int WB_MEMWRITE = 0;
   localparam int WB_MEMREAD  = 1;

   localparam logic [3:0] BE_ALL     = 4'b1111;
   localparam logic [3:0] BE_LO_HALF = 4'b0011;
   localparam logic [3:0] BE_HI_HALF = 4'b1100;
   localparam logic [3:0] BE_BYTE0   = 4'b0001;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Opcodes that do not match the access direction fall back to the word form.
   function automatic logic [5:0] eff_op(input logic wr, input logic [5:0] op);
      if (wr)
         return (op == OP_SB || op == OP_SH || op == OP_SW) ? op : OP_SW;
      return (op == OP_LB || op == OP_LH || op == OP_LW || op == OP_LBU || op == OP_LHU) ? op : OP_LW;
   endfunction

   function automatic logic misaligned(input logic [5:0] op, input logic [1:0] a);
      case (op)
         OP_LH, OP_LHU, OP_SH: return a[0];
         OP_LW, OP_SW:         return (a != 2'b00);
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane logic: store byte-enables and replicated write data,
// plus load lane extraction with sign or zero extension.
module dmem_lane_fmt
   import mem_access_pkg::*;
(
   input  logic [5:0]  op_i,
   input  logic [1:0]  addr_lo_i,
   input  logic [31:0] rt_i,
   input  logic [31:0] rdata_i,
   output logic [3:0]  be_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rfmt_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata_i[{addr_lo_i, 3'b000} +: 8];
      half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
      be_o     = BE_ALL;
      wdata_o  = '0;
      rfmt_o   = rdata_i;
      case (op_i)
         OP_SB: begin
            be_o    = BE_BYTE0 << addr_lo_i;
            wdata_o = {4{rt_i[7:0]}};
         end
         OP_SH: begin
            be_o    = addr_lo_i[1] ? BE_HI_HALF : BE_LO_HALF;
            wdata_o = {2{rt_i[15:0]}};
         end
         OP_SW:  wdata_o = rt_i;
         OP_LB:  rfmt_o  = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU: rfmt_o  = {24'h0, byte_sel};
         OP_LH:  rfmt_o  = {{16{half_sel[15]}}, half_sel};
         OP_LHU: rfmt_o  = {16'h0, half_sel};
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage req/ack initiator toward a variable-latency data memory; stalls the
// pipeline while a transaction is outstanding and aborts on timeout.
module dmem_access_ctrl
   import mem_access_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic [4:0]        WB_MEM,
   input  logic [5:0]        MEM_Opcode,
   input  logic [ADDR_W-1:0] MEM_ALU_RESULT,
   input  logic [31:0]       MEM_RT_DATA,
   output logic              Mem_Req,
   output logic              Mem_We,
   output logic [ADDR_W-1:0] Mem_Addr,
   output logic [31:0]       Mem_WData,
   output logic [3:0]        Mem_BE,
   input  logic              Mem_Ack,
   input  logic [31:0]       Mem_RData,
   output logic [31:0]       Read_data,
   output logic              Stall,
   output logic              Align_Err,
   output logic              Bus_Err
);

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_t            state_q, state_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              req_q, req_d, we_q, we_d, aerr_q, aerr_d, berr_q, berr_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d, rdata_q, rdata_d;
   logic [3:0]        be_q, be_d;
   logic [5:0]        op_q, op_d, op_live, fmt_op;
   logic [1:0]        alo_q, alo_d, fmt_alo;
   logic              access, mis;
   logic [3:0]        lane_be;
   logic [31:0]       lane_wdata, lane_rfmt;
   logic              unused_wb;

   assign unused_wb = ^WB_MEM[4:2];

   // The lane formatter sees the live EX/MEM inputs at issue and the captured op/lane afterwards.
   assign fmt_op  = (state_q == ST_IDLE) ? op_live : op_q;
   assign fmt_alo = (state_q == ST_IDLE) ? MEM_ALU_RESULT[1:0] : alo_q;

   dmem_lane_fmt u_fmt (
      .op_i      (fmt_op),
      .addr_lo_i (fmt_alo),
      .rt_i      (MEM_RT_DATA),
      .rdata_i   (Mem_RData),
      .be_o      (lane_be),
      .wdata_o   (lane_wdata),
      .rfmt_o    (lane_rfmt)
   );

   always_comb begin
      access  = WB_MEM[WB_MEMWRITE] | WB_MEM[WB_MEMREAD];
      op_live = eff_op(WB_MEM[WB_MEMWRITE], MEM_Opcode);
      mis     = misaligned(op_live, MEM_ALU_RESULT[1:0]);
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rdata_d = rdata_q;
      op_d    = op_q;
      alo_d   = alo_q;
      aerr_d  = 1'b0;
      berr_d  = 1'b0;
      Stall   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (access && mis) begin
               aerr_d = 1'b1;
            end else if (access) begin
               Stall   = 1'b1;
               req_d   = 1'b1;
               we_d    = WB_MEM[WB_MEMWRITE];
               addr_d  = {MEM_ALU_RESULT[ADDR_W-1:2], 2'b00};
               wdata_d = lane_wdata;
               be_d    = lane_be;
               op_d    = op_live;
               alo_d   = MEM_ALU_RESULT[1:0];
               cnt_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            Stall = 1'b1;
            if (Mem_Ack) begin
               req_d   = 1'b0;
               if (!we_q) rdata_d = lane_rfmt;
               state_d = ST_DONE;
            end else if (cnt_q == TO_LAST) begin
               req_d   = 1'b0;
               berr_d  = 1'b1;
               rdata_d = '0;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            cnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rdata_q <= '0;
         op_q    <= '0;
         alo_q   <= '0;
         aerr_q  <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rdata_q <= rdata_d;
         op_q    <= op_d;
         alo_q   <= alo_d;
         aerr_q  <= aerr_d;
         berr_q  <= berr_d;
      end
   end

   assign Mem_Req   = req_q;
   assign Mem_We    = we_q;
   assign Mem_Addr  = addr_q;
   assign Mem_WData = wdata_q;
   assign Mem_BE    = be_q;
   assign Read_data = rdata_q;
   assign Align_Err = aerr_q;
   assign Bus_Err   = berr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl: a table of single transactions plus
// hand-written misalignment, timeout and mid-transaction reset sequences.
module tb_dmem_access_ctrl;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [4:0]  WB_MEM;
   logic [5:0]  MEM_Opcode;
   logic [31:0] MEM_ALU_RESULT, MEM_RT_DATA;
   logic        Mem_Req, Mem_We, Mem_Ack;
   logic [31:0] Mem_Addr, Mem_WData, Mem_RData, Read_data;
   logic [3:0]  Mem_BE;
   logic        Stall, Align_Err, Bus_Err;

   int n_chk = 0;
   int n_err = 0;

   always #5 CLK = ~CLK;

   dmem_access_ctrl #(.TIMEOUT_CYCLES(4), .ADDR_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .WB_MEM(WB_MEM), .MEM_Opcode(MEM_Opcode),
      .MEM_ALU_RESULT(MEM_ALU_RESULT), .MEM_RT_DATA(MEM_RT_DATA),
      .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_WData(Mem_WData),
      .Mem_BE(Mem_BE), .Mem_Ack(Mem_Ack), .Mem_RData(Mem_RData), .Read_data(Read_data),
      .Stall(Stall), .Align_Err(Align_Err), .Bus_Err(Bus_Err)
   );

   typedef struct {
      logic [4:0]  wb;
      logic [5:0]  op;
      logic [31:0] addr;
      logic [31:0] rt;
      logic [31:0] rdata;
      int          dly;
      logic        we;
      logic [31:0] eaddr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Entered and left just after a rising edge.
   task automatic run_vec(input vec_t v, input int idx);
      int stall_cnt;
      WB_MEM = v.wb; MEM_Opcode = v.op; MEM_ALU_RESULT = v.addr;
      MEM_RT_DATA = v.rt; Mem_RData = v.rdata;
      @(negedge CLK);
      stall_cnt = Stall ? 1 : 0;
      chk($sformatf("v%0d_req_idle", idx), {31'b0, Mem_Req}, 32'd0);
      for (int i = 1; i <= v.dly; i++) begin
         @(posedge CLK); #1;
         Mem_Ack = (i == v.dly);
         @(negedge CLK);
         if (Stall) stall_cnt++;
         chk($sformatf("v%0d_req_c%0d", idx, i), {31'b0, Mem_Req}, 32'd1);
         if (i == 1) begin
            chk($sformatf("v%0d_we", idx), {31'b0, Mem_We}, {31'b0, v.we});
            chk($sformatf("v%0d_addr", idx), Mem_Addr, v.eaddr);
            chk($sformatf("v%0d_be", idx), {28'b0, Mem_BE}, {28'b0, v.be});
            chk($sformatf("v%0d_wdata", idx), Mem_WData, v.wdata);
         end
      end
      @(posedge CLK); #1;
      Mem_Ack = 1'b0;
      @(negedge CLK);
      if (Stall) stall_cnt++;
      chk($sformatf("v%0d_rdata", idx), Read_data, v.rd);
      chk($sformatf("v%0d_req_done", idx), {31'b0, Mem_Req}, 32'd0);
      chk($sformatf("v%0d_buserr", idx), {31'b0, Bus_Err}, 32'd0);
      chk($sformatf("v%0d_stall_cycles", idx), stall_cnt, v.dly + 1);
      @(posedge CLK); #1;
      WB_MEM = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //            wb      op         addr          rt            rdata        dly we  eaddr         be       wdata         rd
      vecs[0]  = '{5'b00010, 6'b100011, 32'h0000_0004, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 3, 0, 32'h0000_0004, 4'b1111, 32'h0000_0000, 32'hDEAD_BEEF};
      vecs[1]  = '{5'b00001, 6'b101000, 32'h0000_000B, 32'h0000_00A5, 32'h0,         1, 1, 32'h0000_0008, 4'b1000, 32'hA5A5_A5A5, 32'hDEAD_BEEF};
      vecs[2]  = '{5'b00010, 6'b100000, 32'h0000_000A, 32'h0,         32'h0080_0000, 2, 0, 32'h0000_0008, 4'b1111, 32'h0000_0000, 32'hFFFF_FF80};
      vecs[3]  = '{5'b00010, 6'b100100, 32'h0000_000A, 32'h0,         32'h0080_0000, 2, 0, 32'h0000_0008, 4'b1111, 32'h0000_0000, 32'h0000_0080};
      vecs[4]  = '{5'b00001, 6'b101001, 32'h0000_0006, 32'h1234_BEEF, 32'h0,         1, 1, 32'h0000_0004, 4'b1100, 32'hBEEF_BEEF, 32'h0000_0080};
      vecs[5]  = '{5'b00010, 6'b100001, 32'h0000_0002, 32'h0,         32'h8001_7FFF, 2, 0, 32'h0000_0000, 4'b1111, 32'h0000_0000, 32'hFFFF_8001};
      vecs[6]  = '{5'b00010, 6'b100101, 32'h0000_0000, 32'h0,         32'h8001_7FFF, 2, 0, 32'h0000_0000, 4'b1111, 32'h0000_0000, 32'h0000_7FFF};
      vecs[7]  = '{5'b00001, 6'b101011, 32'h0000_0100, 32'hCAFE_F00D, 32'h0,         4, 1, 32'h0000_0100, 4'b1111, 32'hCAFE_F00D, 32'h0000_7FFF};
      vecs[8]  = '{5'b00010, 6'b000000, 32'h0000_0010, 32'h0,         32'h1122_3344, 1, 0, 32'h0000_0010, 4'b1111, 32'h0000_0000, 32'h1122_3344};
      vecs[9]  = '{5'b00011, 6'b100011, 32'h0000_0014, 32'h5566_7788, 32'h0,         2, 1, 32'h0000_0014, 4'b1111, 32'h5566_7788, 32'h1122_3344};
      vecs[10] = '{5'b00001, 6'b101000, 32'h0000_0001, 32'hFFFF_FF3C, 32'h0,         1, 1, 32'h0000_0000, 4'b0010, 32'h3C3C_3C3C, 32'h1122_3344};
      vecs[11] = '{5'b00010, 6'b100000, 32'h0000_0003, 32'h0,         32'h7F00_0000, 1, 0, 32'h0000_0000, 4'b1111, 32'h0000_0000, 32'h0000_007F};
      vecs[12] = '{5'b00010, 6'b100011, 32'h0000_0040, 32'h0,         32'hA5A5_5A5A, 1, 0, 32'h0000_0040, 4'b1111, 32'h0000_0000, 32'hA5A5_5A5A};

      RESET = 1'b1; WB_MEM = '0; MEM_Opcode = '0; MEM_ALU_RESULT = '0;
      MEM_RT_DATA = '0; Mem_Ack = 1'b0; Mem_RData = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_req", {31'b0, Mem_Req}, 32'd0);
      chk("rst_we", {31'b0, Mem_We}, 32'd0);
      chk("rst_addr", Mem_Addr, 32'd0);
      chk("rst_wdata", Mem_WData, 32'd0);
      chk("rst_be", {28'b0, Mem_BE}, 32'd0);
      chk("rst_rdata", Read_data, 32'd0);
      chk("rst_errs", {30'b0, Align_Err, Bus_Err}, 32'd0);
      chk("rst_stall", {31'b0, Stall}, 32'd0);
      @(posedge CLK); #1;
      RESET = 1'b0;

      for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

      // Misaligned half and word loads: error pulse, no request, no stall.
      for (int k = 0; k < 2; k++) begin
         WB_MEM = 5'b00010;
         MEM_Opcode = (k == 0) ? 6'b100001 : 6'b100011;
         MEM_ALU_RESULT = (k == 0) ? 32'h0000_0005 : 32'h0000_0002;
         @(negedge CLK);
         chk($sformatf("mis%0d_stall", k), {31'b0, Stall}, 32'd0);
         chk($sformatf("mis%0d_req0", k), {31'b0, Mem_Req}, 32'd0);
         @(posedge CLK); #1;
         WB_MEM = '0;
         @(negedge CLK);
         chk($sformatf("mis%0d_aerr", k), {31'b0, Align_Err}, 32'd1);
         chk($sformatf("mis%0d_req1", k), {31'b0, Mem_Req}, 32'd0);
         @(posedge CLK); #1;
         @(negedge CLK);
         chk($sformatf("mis%0d_aerr_clr", k), {31'b0, Align_Err}, 32'd0);
         chk($sformatf("mis%0d_rd_hold", k), Read_data, 32'h0000_007F);
         @(posedge CLK); #1;
      end

      // Timeout with no ack: four REQ cycles, then abort.
      WB_MEM = 5'b00010; MEM_Opcode = 6'b100011; MEM_ALU_RESULT = 32'h0000_0020;
      @(negedge CLK);
      chk("to_stall_idle", {31'b0, Stall}, 32'd1);
      for (int i = 1; i <= 4; i++) begin
         @(posedge CLK); #1;
         @(negedge CLK);
         chk($sformatf("to_req_c%0d", i), {31'b0, Mem_Req}, 32'd1);
         chk($sformatf("to_noerr_c%0d", i), {31'b0, Bus_Err}, 32'd0);
         chk($sformatf("to_stall_c%0d", i), {31'b0, Stall}, 32'd1);
      end
      @(posedge CLK); #1;
      WB_MEM = '0;
      @(negedge CLK);
      chk("to_buserr", {31'b0, Bus_Err}, 32'd1);
      chk("to_req_drop", {31'b0, Mem_Req}, 32'd0);
      chk("to_rdata", Read_data, 32'd0);
      chk("to_stall_done", {31'b0, Stall}, 32'd0);
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("to_buserr_clr", {31'b0, Bus_Err}, 32'd0);
      chk("to_idle_stall", {31'b0, Stall}, 32'd0);
      @(posedge CLK); #1;

      run_vec(vecs[12], 12);

      // Reset mid-REQ, then a late ack that must be ignored.
      WB_MEM = 5'b00010; MEM_Opcode = 6'b100011; MEM_ALU_RESULT = 32'h0000_0030;
      Mem_RData = 32'h1234_5678;
      @(posedge CLK); #1;
      @(negedge CLK);
      chk("rq_req", {31'b0, Mem_Req}, 32'd1);
      RESET = 1'b1; WB_MEM = '0;
      @(posedge CLK); #1;
      RESET = 1'b0; Mem_Ack = 1'b1;
      @(negedge CLK);
      chk("rq_req_drop", {31'b0, Mem_Req}, 32'd0);
      chk("rq_stall", {31'b0, Stall}, 32'd0);
      chk("rq_rdata_rst", Read_data, 32'd0);
      @(posedge CLK); #1;
      Mem_Ack = 1'b0;
      @(negedge CLK);
      chk("rq_late_ack_rd", Read_data, 32'd0);
      chk("rq_late_ack_req", {31'b0, Mem_Req}, 32'd0);
      chk("rq_late_ack_stall", {31'b0, Stall}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
      $finish;
   end

endmodule
